// File: rtl/keypad_scan_amisha.sv
// 4x4 matrix keypad scanner: walks a one-cold column, debounces on the rows,
// and emits a hex key code with a one-clock valid strobe and a held flag.
module keypad_scan_amisha #(
  parameter int SCAN_DIV = 50000,
  parameter int DB_COUNT = 4
) (
  input  logic       clk_amisha,
  input  logic       reset_n_amisha,
  input  logic [3:0] row_amisha,
  output logic [3:0] col_amisha,
  output logic [3:0] key_amisha,
  output logic       key_valid_amisha,
  output logic       key_held_amisha
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DB_COUNT > 0) ? $clog2(DB_COUNT + 1) : 1;

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;

  logic [3:0]    r_row_m;
  logic [3:0]    r_rs;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_col_idx;
  logic [1:0]    r_row_idx;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_state;
  logic [3:0]    r_key;
  logic          r_valid;
  logic          r_held;

  logic          w_tick;
  logic          w_any;
  logic [1:0]    w_row_sel;
  logic          w_row_low;

  function automatic logic [3:0] keycode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_comb begin
    w_tick    = (r_presc == PW'(SCAN_DIV - 1));
    w_any     = (r_rs != 4'hF);
    w_row_low = ~r_rs[r_row_idx];
    // Lowest-index low row wins when several rows in a column are pressed.
    if (!r_rs[0])      w_row_sel = 2'd0;
    else if (!r_rs[1]) w_row_sel = 2'd1;
    else if (!r_rs[2]) w_row_sel = 2'd2;
    else               w_row_sel = 2'd3;
  end

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      r_row_m   <= '1;
      r_rs      <= '1;
      r_presc   <= '0;
      r_col_idx <= '0;
      r_row_idx <= '0;
      r_cnt     <= '0;
      r_state   <= S_SCAN;
      r_key     <= '0;
      r_valid   <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_row_m <= row_amisha;
      r_rs    <= r_row_m;
      r_valid <= 1'b0;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (!w_any) begin
              r_col_idx <= r_col_idx + 1'b1;
            end else begin
              r_row_idx <= w_row_sel;
              if (DB_COUNT == 1) begin
                r_key   <= keycode(w_row_sel, r_col_idx);
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_cnt   <= '0;
                r_state <= S_HOLD;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= S_DEBOUNCE;
              end
            end
          end
          S_DEBOUNCE: begin
            if (w_row_low) begin
              if (r_cnt == CW'(DB_COUNT - 1)) begin
                r_key   <= keycode(r_row_idx, r_col_idx);
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_cnt   <= '0;
                r_state <= S_HOLD;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_cnt     <= '0;
              r_col_idx <= r_col_idx + 1'b1;
              r_state   <= S_SCAN;
            end
          end
          S_HOLD: begin
            // Any low row keeps the key held; only a full run of idle ticks releases it.
            if (!w_any) begin
              if (r_cnt == CW'(DB_COUNT - 1)) begin
                r_held    <= 1'b0;
                r_cnt     <= '0;
                r_col_idx <= r_col_idx + 1'b1;
                r_state   <= S_SCAN;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

  always_comb begin
    col_amisha       = ~(4'b0001 << r_col_idx);
    key_amisha       = r_key;
    key_valid_amisha = r_valid;
    key_held_amisha  = r_held;
  end

endmodule

// File: tb/tb_keypad_scan_amisha.sv
// Scoreboard bench for keypad_scan_amisha with a switch-matrix keypad model
// (row pulled low while its key is pressed and that key's column is driven low).
module tb_keypad_scan_amisha;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;   // bit r*4+c
  logic [3:0]  exp_q[$];
  int          total;
  int          bad;

  keypad_scan_amisha #(.SCAN_DIV(4), .DB_COUNT(3)) dut (
    .clk_amisha       (clk),
    .reset_n_amisha   (rst_n),
    .row_amisha       (row),
    .col_amisha       (col),
    .key_amisha       (key),
    .key_valid_amisha (key_valid),
    .key_held_amisha  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got key %h want no valid at %0t", key, $time);
      end else begin
        check("valid_key", key, exp_q.pop_front());
        check("held_at_valid", {3'b0, key_held}, 4'h1);
      end
    end
  end

  task automatic wait_held(input logic v, input string nm);
    int n = 0;
    while (key_held !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(nm, {3'b0, key_held}, {3'b0, v});
  endtask

  task automatic wait_col(input logic [3:0] v, input string nm);
    int n = 0;
    while (col !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, col, v);
  endtask

  task automatic press(input logic [15:0] m, input logic [3:0] k);
    logic [3:0] c0;
    int n;
    pressed = m;
    exp_q.push_back(k);
    wait_held(1'b1, "held_rise");
    repeat (5) @(negedge clk);
    pressed = '0;
    wait_held(1'b0, "held_fall");
    check("key_kept", key, k);
    c0 = col;
    n = 0;
    while (col === c0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("col_resume", {3'b0, col !== c0}, 4'h1);
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_col"}, col, 4'b1110);
    check({nm, "_key"}, key, 4'h0);
    check({nm, "_valid"}, {3'b0, key_valid}, 4'h0);
    check({nm, "_held"}, {3'b0, key_held}, 4'h0);
  endtask

  initial begin
    logic [3:0] e;
    total   = 0;
    bad     = 0;
    pressed = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;

    // Rotation: column index advances on every 4th edge after reset release.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      e = 4'b1111;
      e[(k / 4) % 4] = 1'b0;
      check("rotate", col, e);
    end

    press(16'h1 << (1*4+2), 4'h6);

    // Bounce: one low tick in column 0, then released before the second.
    wait_col(4'b0111, "sync_c3");
    wait_col(4'b1110, "sync_c0");
    pressed = 16'h0001;
    repeat (4) @(negedge clk);
    check("debounce_frozen", col, 4'b1110);
    pressed = '0;
    repeat (4) @(negedge clk);
    check("bounce_col", col, 4'b1101);
    check("bounce_held", {3'b0, key_held}, 4'h0);
    press(16'h1 << (0*4+0), 4'h1);

    press(16'h1 << (3*4+0), 4'hE);
    press(16'h1 << (3*4+2), 4'hF);
    press((16'h1 << (2*4+3)) | (16'h1 << (3*4+3)), 4'hC);

    // Long hold with a second-column press that must be ignored.
    pressed = 16'h1 << (0*4+3);
    exp_q.push_back(4'hA);
    wait_held(1'b1, "long_held_rise");
    pressed = pressed | (16'h1 << (1*4+0));
    repeat (200) @(negedge clk);
    check("long_held", {3'b0, key_held}, 4'h1);
    check("long_key", key, 4'hA);
    check("long_col_frozen", col, 4'b0111);
    pressed = 16'h1 << (0*4+3);
    repeat (2) @(negedge clk);
    pressed = '0;
    wait_held(1'b0, "long_held_fall");
    repeat (40) @(negedge clk);

    // Reset in DEBOUNCE (r1/c1).
    wait_col(4'b1110, "rd_sync_c0");
    pressed = 16'h1 << (1*4+1);
    wait_col(4'b1101, "rd_sync_c1");
    repeat (5) @(negedge clk);
    check("rd_frozen", col, 4'b1101);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_deb");
    pressed = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_deb_after_held", {3'b0, key_held}, 4'h0);

    // Reset in HOLD (r2/c1 -> 8).
    pressed = 16'h1 << (2*4+1);
    exp_q.push_back(4'h8);
    wait_held(1'b1, "rh_held_rise");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_hold");
    pressed = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_hold_after_key", key, 4'h0);
    check("rst_hold_after_held", {3'b0, key_held}, 4'h0);

    check("pending_expected", 4'(exp_q.size()), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
